// File: rtl/mat3_pkg.sv
// rtl/mat3_pkg.sv - shared constants, state encoding and operand types for mat3_seq_mul
package mat3_pkg;

    localparam int MAT3_DIM    = 3;
    localparam int MAT3_IN_W   = 8;
    localparam int MAT3_OUT_W  = 16;
    localparam int MAT3_NBYTES = 18;
    localparam int MAT3_NRES   = 9;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } mat3_state_t;

    // One matrix element and a packed 3-element row/column (element 0 in the MSBs)
    typedef logic [MAT3_IN_W-1:0]          elem_t;
    typedef logic [MAT3_DIM*MAT3_IN_W-1:0] vec_t;

endpackage

// File: rtl/dot3_u8.sv
// rtl/dot3_u8.sv - combinational 3-element unsigned dot product, optional saturation under MAT3_SAT_EN
module dot3_u8
    import mat3_pkg::*;
(
    input  vec_t                  i_a,
    input  vec_t                  i_b,
    output logic [MAT3_OUT_W-1:0] o_res
);

`ifdef MAT3_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [17:0] w_sum;

    // Full-precision sum: 3 * 255 * 255 = 195075 fits in 18 bits
    always_comb begin
        w_sum = 18'(i_a[23:16]) * 18'(i_b[23:16])
              + 18'(i_a[15:8])  * 18'(i_b[15:8])
              + 18'(i_a[7:0])   * 18'(i_b[7:0]);
    end

    // Clamp to all-ones when saturating, otherwise keep the low 16 bits
    always_comb begin
        o_res = w_sum[15:0];
        if (SAT && (|w_sum[17:16])) begin
            o_res = 16'hFFFF;
        end
    end

endmodule

// File: rtl/mat3_seq_mul.sv
// rtl/mat3_seq_mul.sv - sequential 3x3 byte-stream matrix multiplier (saturation option: MAT3_SAT_EN)
module mat3_seq_mul
    import mat3_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int DIM   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam int NBYTES = 2 * DIM * DIM;
    localparam int NRES   = DIM * DIM;

    mat3_state_t      r_state;
    mat3_state_t      w_next;
    logic [4:0]       r_cnt;
    logic [3:0]       r_idx;
    elem_t            r_mat [NBYTES];
    logic [OUT_W-1:0] r_out_data;

    logic             w_accept_in;
    logic             w_accept_out;
    logic             w_last_in;
    logic             w_last_out;
    logic [3:0]       w_sel;
    logic [1:0]       w_row;
    logic [1:0]       w_col;
    vec_t             w_rows [DIM];
    vec_t             w_cols [DIM];
    logic [15:0]      w_res;

    assign w_accept_in  = in_valid && (r_state == LOAD);
    assign w_accept_out = out_ready && (r_state == SEND);
    assign w_last_in    = w_accept_in && (r_cnt == 5'(NBYTES - 1));
    assign w_last_out   = w_accept_out && (r_idx == 4'(NRES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; done fires in the cycle the last word is taken
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                if (w_last_in) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                busy   = 1'b1;
                w_next = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (w_last_out) begin
                    done   = 1'b1;
                    w_next = LOAD;
                end
            end
            default: w_next = LOAD;
        endcase
    end

    // Operand capture: bytes land in load order, A in 0..8 and B in 9..17
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            for (int k = 0; k < NBYTES; k++) begin
                r_mat[k] <= '0;
            end
        end else if (w_accept_in) begin
            r_mat[r_cnt] <= in_data;
            r_cnt        <= w_last_in ? 5'd0 : r_cnt + 5'd1;
        end
    end

    // Pack rows of A and columns of B, element 0 in the MSBs
    for (genvar g = 0; g < DIM; g++) begin : g_pack
        assign w_rows[g] = {r_mat[DIM*g], r_mat[DIM*g+1], r_mat[DIM*g+2]};
        assign w_cols[g] = {r_mat[DIM*DIM+g], r_mat[DIM*DIM+DIM+g], r_mat[DIM*DIM+2*DIM+g]};
    end

    // The shared dot product always looks one word ahead of the one being presented
    assign w_sel = (r_state == SEND) ? (r_idx + 4'd1) : 4'd0;

    // Map the flat result index to (row, column)
    always_comb begin
        w_row = 2'd0;
        w_col = 2'd0;
        case (w_sel)
            4'd0: begin w_row = 2'd0; w_col = 2'd0; end
            4'd1: begin w_row = 2'd0; w_col = 2'd1; end
            4'd2: begin w_row = 2'd0; w_col = 2'd2; end
            4'd3: begin w_row = 2'd1; w_col = 2'd0; end
            4'd4: begin w_row = 2'd1; w_col = 2'd1; end
            4'd5: begin w_row = 2'd1; w_col = 2'd2; end
            4'd6: begin w_row = 2'd2; w_col = 2'd0; end
            4'd7: begin w_row = 2'd2; w_col = 2'd1; end
            4'd8: begin w_row = 2'd2; w_col = 2'd2; end
            default: begin w_row = 2'd0; w_col = 2'd0; end
        endcase
    end

    dot3_u8 u_dot (
        .i_a   (w_rows[w_row]),
        .i_b   (w_cols[w_col]),
        .o_res (w_res)
    );

    // Result register: C[0][0] in CALC, then the next word on each accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                CALC: begin
                    r_idx      <= '0;
                    r_out_data <= w_res;
                end
                SEND: begin
                    if (w_accept_out) begin
                        if (w_last_out) begin
                            r_idx <= '0;
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_out_data <= w_res;
                        end
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    assign out_data = r_out_data;

endmodule

// File: tb/tb_mat3_seq_mul.sv
// tb/tb_mat3_seq_mul.sv - self-checking bench for mat3_seq_mul against a behavioural matrix model
module tb_mat3_seq_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  job  [18];
    logic [7:0]  job2 [18];
    int          exp_c [9];

    mat3_seq_mul dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: plain matrix product of the bytes in job, wrapped or saturated
    function automatic void model();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++) begin
                    s += int'(job[3*i+k]) * int'(job[9+3*k+j]);
                end
`ifdef MAT3_SAT_EN
                exp_c[3*i+j] = (s > 65535) ? 65535 : s;
`else
                exp_c[3*i+j] = s % 65536;
`endif
            end
        end
    endfunction

    task automatic drive_load(input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            in_valid = 1'b1;
            in_data  = job[k];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready byte %0d: in_ready=%b expected 1", k, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: low 5 cycles then every other cycle
    task automatic receive(input int mode, input string name);
        int          n;
        int          cyc;
        logic        stalled;
        logic [15:0] held;
        logic        exp_done;
        n       = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (n < 9 && cyc < 300) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= 5) && (((cyc - 5) % 2) == 0);
            endcase
            #1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL %s stall_hold: valid=%b data=%h expected valid=1 data=%h", name, out_valid, out_data, held);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_in_send: in_ready=%b expected 0", name, in_ready);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                exp_done = (n == 8);
                checks += 2;
                if (out_data !== 16'(exp_c[n])) begin
                    errors++;
                    $display("FAIL %s word%0d: out_data=%h expected %h", name, n, out_data, 16'(exp_c[n]));
                end
                if (done !== exp_done) begin
                    errors++;
                    $display("FAIL %s done_at_word%0d: done=%b expected %b", name, n, done, exp_done);
                end
                n++;
                stalled = 1'b0;
            end else begin
                stalled = (out_valid === 1'b1);
                held    = out_data;
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_idle: done=%b expected 0", name, done);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL %s word_count: got %0d words expected 9 (timeout)", name, n);
        end
        #1;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post_job: done=%b out_valid=%b in_ready=%b busy=%b expected 0 0 1 0",
                     name, done, out_valid, in_ready, busy);
        end
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h busy=%b done=%b expected 1 0 0000 0 0",
                     in_ready, out_valid, out_data, busy, done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic fill_identity();
        for (int k = 0; k < 9; k++) begin
            job[k]   = (k == 0 || k == 4 || k == 8) ? 8'd1 : 8'd0;
            job[9+k] = 8'(k + 1);
        end
    endtask

    task automatic test_identity();
        fill_identity();
        model();
        drive_load(18);
        receive(0, "identity");
    endtask

    task automatic test_all_ff();
        for (int k = 0; k < 18; k++) job[k] = 8'hFF;
        model();
        drive_load(18);
        receive(0, "all_ff");
    endtask

    task automatic test_squares_latency();
        for (int k = 0; k < 9; k++) begin
            job[k]   = 8'(k + 1);
            job[9+k] = 8'(k + 1);
        end
        model();
        drive_load(18);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL calc_cycle: out_valid=%b busy=%b in_ready=%b expected 0 1 0", out_valid, busy, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'(exp_c[0])) begin
            errors++;
            $display("FAIL first_latency: out_valid=%b out_data=%h expected 1 %h", out_valid, out_data, 16'(exp_c[0]));
        end
        receive(0, "squares");
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 9; k++) begin
            job[k]   = 8'(k + 1);
            job[9+k] = 8'(k + 1);
        end
        model();
        drive_load(18);
        receive(2, "backpressure");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 18; k++) job[k] = 8'($urandom_range(1, 255));
        drive_load(10);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load: in_ready=%b busy=%b out_valid=%b expected 1 0 0", in_ready, busy, out_valid);
        end
        @(posedge clk); #1;
        fill_identity();
        model();
        drive_load(18);
        receive(0, "after_reset");
        for (int k = 0; k < 18; k++) job[k] = 8'($urandom_range(0, 255));
        drive_load(18);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reach_send: out_valid=%b expected 1", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_send: out_valid=%b busy=%b out_data=%h in_ready=%b expected 0 0 0000 1",
                     out_valid, busy, out_data, in_ready);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 18; k++) begin
            job[k]  = 8'($urandom_range(0, 255));
            job2[k] = 8'($urandom_range(0, 255));
        end
        model();
        drive_load(18);
        in_valid = 1'b1;
        in_data  = job2[0];
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_calc_ready: in_ready=%b expected 0", in_ready);
        end
        receive(0, "b2b_job1");
        for (int k = 0; k < 18; k++) job[k] = job2[k];
        model();
        drive_load(18);
        receive(0, "b2b_job2");
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 18; k++) job[k] = 8'($urandom_range(0, 255));
            model();
            drive_load(18);
            receive(1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_ff();
        test_squares_latency();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
